// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one full-adder cell
// reused every clock with a registered carry between bits.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.

// Single-bit full-adder cell that the serial datapath drives each cycle.
module fulladder_db (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Upper WIDTH-1 bits of the collected sum; the newest bit enters at the top.
    logic [WIDTH-2:0]   r_s_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               w_fa_s;
    logic               w_fa_cout;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH-1:0]   w_s_full;

    fulladder_db u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
    // Shift-register contents after this cycle's bit; equals the full sum on the last bit.
    assign w_s_full = {w_fa_s, r_s_sh};

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign s    = r_s;
    assign cout = r_cout;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE on last bit, DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture, per-bit shifting and result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_s_sh  <= w_s_full[WIDTH-1:1];
            r_carry <= w_fa_cout;
            if (w_last) begin
                // Park the counter at zero rather than letting it run past WIDTH-1.
                r_cnt  <= '0;
                r_s    <= w_s_full;
                r_cout <= w_fa_cout;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;

    // Signed overflow: carry into the MSB (the registered carry on the last bit) XOR carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_fa_cout;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder at WIDTH=8 and an exhaustive sweep at WIDTH=2.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] s8;
    logic       cout8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2;
    logic       done2;
    logic [1:0] s2;
    logic       cout2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .s     (s2),
        .cout  (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start an 8-bit add and watch it; lat = cycles from start edge to done, busy_n = busy cycles.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output int busy_n);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = -1;
        busy_n = 0;
        for (int k = 0; k < 14; k++) begin
            if (busy8) busy_n++;
            if (done8 && lat < 0) lat = k;
            if (k < 13) tick();
        end
        $display("add8 a=%02h b=%02h cin=%0d -> s=%02h cout=%0d lat=%0d busy=%0d",
                 a, b, c, s8, cout8, lat, busy_n);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c);
        int lat;
        logic [2:0] exp_sum;
        a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = -1;
        for (int k = 0; k < 6; k++) begin
            if (done2 && lat < 0) lat = k;
            if (k < 5) tick();
        end
        exp_sum = 3'(a) + 3'(b) + 3'(c);
        $display("add2 a=%0d b=%0d cin=%0d -> cout=%0d s=%0d lat=%0d", a, b, c, cout2, s2, lat);
        check($sformatf("w2_sum_%0d_%0d_%0d", a, b, c), {61'd0, cout2, s2}, {61'd0, exp_sum});
        if (lat != 2) check("w2_latency", 64'(lat), 64'd2);
`ifdef SERIAL_ADDER_OVF_EN
        begin
            logic [1:0] low;
            low = 2'(a[0]) + 2'(b[0]) + 2'(c);
            check("w2_ovf", {63'd0, ovf2}, {63'd0, low[1] ^ exp_sum[2]});
        end
`endif
    endtask

    initial begin
        int lat;
        int busy_n;
        int bad;
        int done_seen;

        // Asynchronous reset asserted mid-cycle.
        #3 rst = 1'b1;
        #1;
        check("rst_busy", {63'd0, busy8}, 64'd0);
        check("rst_done", {63'd0, done8}, 64'd0);
        check("rst_s",    {56'd0, s8},    64'd0);
        check("rst_cout", {63'd0, cout8}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle with start low: nothing moves.
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy8 || done8 || s8 != 8'h00 || cout8) bad++;
        end
        check("idle_quiet", 64'(bad), 64'd0);

        // Basic add.
        run8(8'h35, 8'h4A, 1'b0, lat, busy_n);
        check("basic_s",    {56'd0, s8},    64'h7F);
        check("basic_cout", {63'd0, cout8}, 64'd0);
        check("basic_lat",  64'(lat),       64'd8);
        check("basic_busy", 64'(busy_n),    64'd9);
        check("basic_hold", {56'd0, s8},    64'h7F);

        // Carry ripples through every bit.
        run8(8'hFF, 8'h00, 1'b1, lat, busy_n);
        check("ripple_s",    {56'd0, s8},    64'h00);
        check("ripple_cout", {63'd0, cout8}, 64'd1);
        check("ripple_lat",  64'(lat),       64'd8);
`ifdef SERIAL_ADDER_OVF_EN
        check("ripple_ovf",  {63'd0, ovf8},  64'd0);
        run8(8'h7F, 8'h01, 1'b0, lat, busy_n);
        check("ovf1_s",    {56'd0, s8},    64'h80);
        check("ovf1_cout", {63'd0, cout8}, 64'd0);
        check("ovf1_ovf",  {63'd0, ovf8},  64'd1);
        run8(8'h80, 8'h80, 1'b0, lat, busy_n);
        check("ovf2_s",    {56'd0, s8},    64'h00);
        check("ovf2_cout", {63'd0, cout8}, 64'd1);
        check("ovf2_ovf",  {63'd0, ovf8},  64'd1);
`endif

        // Busy protection, then back-to-back start at the first idle cycle.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'hEE; b8 = 8'hEE; cin8 = 1'b1;
        lat = -1;
        for (int k = 0; k < 9; k++) begin
            start8 = (k == 3 || k == 8);
            if (done8 && lat < 0) lat = k;
            tick();
        end
        start8 = 1'b0;
        $display("add8 a=10 b=20 cin=0 with ignored starts -> s=%02h cout=%0d lat=%0d", s8, cout8, lat);
        check("prot_lat",  64'(lat),       64'd8);
        check("prot_s",    {56'd0, s8},    64'h30);
        check("prot_cout", {63'd0, cout8}, 64'd0);
        check("prot_idle", {63'd0, busy8}, 64'd0);
        run8(8'h01, 8'h02, 1'b0, lat, busy_n);
        check("b2b_s",   {56'd0, s8}, 64'h03);
        check("b2b_lat", 64'(lat),    64'd8);

        // Reset during the 4th SHIFT cycle aborts the operation.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy8}, 64'd0);
        check("abort_s",    {56'd0, s8},    64'd0);
        check("abort_cout", {63'd0, cout8}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8 || busy8) done_seen++;
            tick();
        end
        $display("abort a=12 b=34 -> s=%02h cout=%0d activity=%0d", s8, cout8, done_seen);
        check("abort_no_done", 64'(done_seen), 64'd0);
        run8(8'hAA, 8'h55, 1'b0, lat, busy_n);
        check("post_abort_s",    {56'd0, s8},    64'hFF);
        check("post_abort_cout", {63'd0, cout8}, 64'd0);

        // Exhaustive sweep at WIDTH=2.
        for (int i = 0; i < 32; i++) begin
            run2(2'(i >> 3), 2'(i >> 1), 1'(i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
